// File: rtl/hack_ctrl.sv
// hack_ctrl
//   Control and register stage in front of a 16-bit Hack-style ALU.
//   Accepts one Hack instruction at a time over a valid/ready handshake.
//   Holds the architectural A, D and PC registers.
//   Fetches the memory operand M when the instruction's a-bit is set.
//   Drives the ALU operands and select from registered state.
//   Consumes the ALU result and flags for writeback and jump resolution.
//   Sequence per instruction: FETCH -> (MREAD) -> EXEC -> FETCH.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   instr_valid/instr  instruction offered by upstream
//   instr_ready        high in FETCH; transfer on valid & ready
//   pc                 address of the next instruction (WIDTH-1 bits)
//   alu_x, alu_y       ALU operands
//   alu_select         [5:4] x mode, [3:2] y mode, [1] f, [0] no
//   alu_out/zr/ng      ALU result and flags, sampled at the EXEC edge
//   mem_addr           always A[WIDTH-2:0]
//   mem_re             read request, held for all of MREAD
//   mem_rdata/rvalid   read data and its valid strobe
//   mem_we/mem_wdata   one-cycle write strobe in EXEC; data is alu_out
//   a_reg, d_reg       architectural A and D, for debug
module hack_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [WIDTH-1:0]   instr,
  output logic               instr_ready,
  output logic [WIDTH-2:0]   pc,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  output logic [5:0]         alu_select,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_zr,
  input  logic               alu_ng,
  output logic [WIDTH-2:0]   mem_addr,
  output logic               mem_re,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_rvalid,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH-1:0]   a_reg,
  output logic [WIDTH-1:0]   d_reg
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MREAD = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-2:0] pc_q, pc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] instr_q, instr_d;

  // Decode of the latched C-instruction fields.
  logic a_bit, zx, nx, zy, ny, f_bit, no_bit;
  logic dest_a, dest_d, dest_m;
  logic jmp_lt, jmp_eq, jmp_gt;
  logic jump_taken;

  assign a_bit  = instr_q[12];
  assign zx     = instr_q[11];
  assign nx     = instr_q[10];
  assign zy     = instr_q[9];
  assign ny     = instr_q[8];
  assign f_bit  = instr_q[7];
  assign no_bit = instr_q[6];
  assign dest_a = instr_q[5];
  assign dest_d = instr_q[4];
  assign dest_m = instr_q[3];
  assign jmp_lt = instr_q[2];
  assign jmp_eq = instr_q[1];
  assign jmp_gt = instr_q[0];

  // Bit 15 only steers FETCH (taken from the live instr); bits 14:13 are don't-care.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_q[WIDTH-1:13];

  // The ALU's own zero+invert mode gives 0, not all-ones, so zx&nx is
  // realised by passing a forced all-ones operand instead.
  logic [WIDTH-1:0] y_src;
  assign y_src = a_bit ? m_q : a_q;

  always_comb begin
    if (zx && nx) begin
      alu_select[5:4] = 2'b00;
      alu_x           = '1;
    end else begin
      alu_select[5:4] = {nx, zx};
      alu_x           = d_q;
    end
    if (zy && ny) begin
      alu_select[3:2] = 2'b00;
      alu_y           = '1;
    end else begin
      alu_select[3:2] = {ny, zy};
      alu_y           = y_src;
    end
    alu_select[1] = f_bit;
    alu_select[0] = no_bit;
  end

  assign jump_taken = (jmp_lt & alu_ng) | (jmp_eq & alu_zr) |
                      (jmp_gt & ~alu_ng & ~alu_zr);

  // Handshake and memory strobes are pure functions of state.
  assign instr_ready = (state_q == FETCH);
  assign mem_re      = (state_q == MREAD);
  assign mem_we      = (state_q == EXEC) && dest_m;
  assign mem_addr    = a_q[WIDTH-2:0];   // pre-update A during EXEC
  assign mem_wdata   = alu_out;
  assign pc          = pc_q;
  assign a_reg       = a_q;
  assign d_reg       = d_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    m_d     = m_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          if (!instr[15]) begin
            a_d  = instr;
            pc_d = pc_q + 1'b1;
          end else begin
            state_d = instr[12] ? MREAD : EXEC;
          end
        end
      end
      MREAD: begin
        if (mem_rvalid) begin
          m_d     = mem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dest_a) a_d = alu_out;
        if (dest_d) d_d = alu_out;
        // Jump target is the A value before this cycle's writeback.
        pc_d    = jump_taken ? a_q[WIDTH-2:0] : pc_q + 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      m_q     <= m_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_hack_ctrl.sv
module tb_hack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] alu_x, alu_y;
  logic [5:0]  alu_select;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic [14:0] mem_addr;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] a_reg, d_reg;

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  int lat;

  hack_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .pc(pc), .alu_x(alu_x), .alu_y(alu_y), .alu_select(alu_select),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .a_reg(a_reg), .d_reg(d_reg)
  );

  always #5 clk = ~clk;

  // Reference Hack ALU: mode 00 pass, 01 zero, 10 invert, 11 zero.
  function automatic logic [15:0] opnd(input logic [1:0] m, input logic [15:0] v);
    case (m)
      2'b00:   return v;
      2'b10:   return ~v;
      default: return 16'h0000;
    endcase
  endfunction

  logic [15:0] xv, yv, rv;
  always_comb begin
    xv = opnd(alu_select[5:4], alu_x);
    yv = opnd(alu_select[3:2], alu_y);
    rv = alu_select[1] ? (xv + yv) : (xv & yv);
    if (alu_select[0]) rv = ~rv;
    alu_out = rv;
  end
  assign alu_zr = (alu_out == 16'h0000);
  assign alu_ng = alu_out[15];

  always @(posedge clk) if (mem_we) we_count <= we_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction and return #1 after the accepting edge.
  task automatic issue(input logic [15:0] w);
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = 16'h0000;
  endtask

  // Cycles from the accepting edge to the edge at which ready is back.
  task automatic wait_ready(output int n);
    n = 1;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    mem_rvalid  = 1'b0;
    mem_rdata   = 16'h0000;
    #3 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pc", pc, 0);
    chk("rst_a", a_reg, 0);
    chk("rst_d", d_reg, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_alu_y", alu_y, 0);
    chk("rst_sel", alu_select, 0);
    rst_n = 1'b1;
    tick();

    // @5 ; D=A
    issue(16'h0005);
    wait_ready(lat);
    chk("ainst_lat", lat, 1);
    chk("ainst_a", a_reg, 16'h0005);
    chk("ainst_pc", pc, 1);
    issue(16'hEC10);
    wait_ready(lat);
    chk("c_a0_lat", lat, 2);
    chk("dA_d", d_reg, 16'h0005);
    chk("dA_a", a_reg, 16'h0005);
    chk("dA_pc", pc, 2);

    // D=-1 via forced all-ones x operand
    issue(16'hEE90);
    chk("neg1_sel_x", alu_select[5:4], 2'b00);
    chk("neg1_alu_x", alu_x, 16'hFFFF);
    chk("neg1_we", mem_we, 0);
    tick();
    chk("neg1_d", d_reg, 16'hFFFF);
    chk("neg1_pc", pc, 3);

    // D=7 ; @100 ; M=D+1
    issue(16'h0007);
    issue(16'hEC10);
    wait_ready(lat);
    issue(16'h0064);
    issue(16'hE7C8);
    chk("mw_we", mem_we, 1);
    chk("mw_addr", mem_addr, 100);
    chk("mw_wdata", mem_wdata, 16'h0008);
    chk("mw_ready", instr_ready, 0);
    tick();
    chk("mw_we_off", mem_we, 0);
    chk("mw_d", d_reg, 16'h0007);
    chk("mw_pc", pc, 7);

    // D=M with 3 wait cycles
    issue(16'hFC10);
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      chk("mr_re_wait", mem_re, 1);
      chk("mr_ready_wait", instr_ready, 0);
      tick();
      lat++;
    end
    chk("mr_addr", mem_addr, 100);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    tick();
    lat++;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    chk("mr_exec_re", mem_re, 0);
    chk("mr_exec_ready", instr_ready, 0);
    tick();
    lat++;
    chk("mr_lat", lat, 6);
    chk("mr_ready", instr_ready, 1);
    chk("mr_d", d_reg, 16'h1234);
    chk("mr_pc", pc, 8);

    // D=0 ; @10 ; D;JEQ -> taken
    issue(16'h0000);
    issue(16'hEC10);
    wait_ready(lat);
    issue(16'h000A);
    issue(16'hE302);
    wait_ready(lat);
    chk("jeq_taken_pc", pc, 10);

    // D=3 ; @10 ; D;JEQ -> not taken (pc 13 -> 14)
    issue(16'h0003);
    issue(16'hEC10);
    wait_ready(lat);
    issue(16'h000A);
    issue(16'hE302);
    wait_ready(lat);
    chk("jeq_nt_pc", pc, 14);

    // @0x7FFF ; D;JMP ; then an A-instruction wraps pc to 0
    issue(16'h7FFF);
    issue(16'hE307);
    wait_ready(lat);
    chk("jmp_pc", pc, 15'h7FFF);
    issue(16'h0001);
    chk("wrap_pc", pc, 0);
    chk("wrap_a", a_reg, 16'h0001);

    // Reset while waiting in MREAD
    issue(16'hFC10);
    chk("abort_re_pre", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pc", pc, 0);
    chk("abort_a", a_reg, 0);
    chk("abort_d", d_reg, 0);
    chk("abort_re", mem_re, 0);
    chk("abort_ready", instr_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_we_count", we_count, 1);

    // Post-reset sanity
    issue(16'h0003);
    issue(16'hEC10);
    wait_ready(lat);
    chk("post_d", d_reg, 16'h0003);
    chk("post_pc", pc, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
